// File: rtl/block_mem_responder.sv
// Block-granular memory below the cache: one line fill or write-back per
// request, completed after a fixed latency with a one-cycle Rdy_Low strobe.
module block_mem_responder #(
  parameter int BLOCK_W   = 128,
  parameter int ALOW_W    = 28,
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 4,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Req_Low,
  input  logic               Wr_Low,
  input  logic [ALOW_W-1:0]  A_Low,
  input  logic [BLOCK_W-1:0] DO_Low,
  output logic [BLOCK_W-1:0] DI_Low,
  output logic               Rdy_Low,
  output logic               Busy,
  output logic [CNT_W-1:0]   Rd_Count,
  output logic [CNT_W-1:0]   Wr_Count
);

  localparam int LAT_W = 8;
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [BLOCK_W-1:0]   data_q, data_d;
  logic [BLOCK_W-1:0]   di_q, di_d;
  logic                 rdy_q, rdy_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic                 mem_we;

  logic [BLOCK_W-1:0]   mem [DEPTH];

  // Upper block-address bits alias onto the same storage.
  logic unused_a_hi;
  assign unused_a_hi = ^A_Low[ALOW_W-1:ADDR_BITS];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    di_d     = di_q;
    rdy_d    = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req_Low) begin
          wr_d    = Wr_Low;
          addr_d  = A_Low[ADDR_BITS-1:0];
          data_d  = DO_Low;
          cnt_d   = LAT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_W'(1);
        end else begin
          // Commit edge: the array write and the counters land together.
          state_d = S_DONE;
          rdy_d   = 1'b1;
          if (wr_q) begin
            mem_we = 1'b1;
            if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end else begin
            di_d = mem[addr_q];
            if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        // Requests seen here are dropped, forcing one turnaround cycle.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      di_q     <= '0;
      rdy_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      di_q     <= di_d;
      rdy_q    <= rdy_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage survives reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[addr_q] <= data_q;
  end

  assign DI_Low   = di_q;
  assign Rdy_Low  = rdy_q;
  assign Busy     = (state_q != S_IDLE);
  assign Rd_Count = rd_cnt_q;
  assign Wr_Count = wr_cnt_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// Randomized scoreboard bench: a transaction-level memory model predicts each
// completion (cycle, data, counters); a monitor checks every Rdy_Low strobe.
module tb_block_mem_responder;

  localparam int LAT  = 4;
  localparam int CW4  = 4;
  localparam int SAT4 = (1 << CW4) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req = 1'b0, wr = 1'b0;
  logic [27:0]  a = '0;
  logic [127:0] dout = '0;
  logic [127:0] di4;
  logic         rdy4, busy4;
  logic [CW4-1:0] rdc4, wrc4;

  logic         req1 = 1'b0, wr1 = 1'b0;
  logic [27:0]  a1 = '0;
  logic [127:0] do1 = '0;
  logic [127:0] di1;
  logic         rdy1, busy1;
  logic [15:0]  rdc1, wrc1;

  always #5 clk = ~clk;

  block_mem_responder #(.LATENCY(LAT), .CNT_W(CW4)) dut4 (
    .clk(clk), .rst(rst), .Req_Low(req), .Wr_Low(wr), .A_Low(a), .DO_Low(dout),
    .DI_Low(di4), .Rdy_Low(rdy4), .Busy(busy4), .Rd_Count(rdc4), .Wr_Count(wrc4));

  block_mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .Req_Low(req1), .Wr_Low(wr1), .A_Low(a1), .DO_Low(do1),
    .DI_Low(di1), .Rdy_Low(rdy1), .Busy(busy1), .Rd_Count(rdc1), .Wr_Count(wrc1));

  typedef struct {
    bit           is_wr;
    logic [127:0] di;
    int           rdy_cyc;
    int           rdc;
    int           wrc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0, errors = 0;
  int           next_free = 0;
  logic [127:0] mdl [int];
  logic [127:0] last_rd = '0;
  int           m_rdc = 0, m_wrc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Monitor: every completion strobe must match the oldest predicted one.
  always @(negedge clk) begin
    if (rdy4 === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_rdy", 128'(rdy4), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdy_cycle", 128'(cyc), 128'(e.rdy_cyc));
        chk(e.is_wr ? "di_hold_on_write" : "read_data", di4, e.di);
        chk("rd_count", 128'(rdc4), 128'(e.rdc));
        chk("wr_count", 128'(wrc4), 128'(e.wrc));
      end
    end
  end

  // Called just after a falling edge; returns just after the falling edge
  // where the completion was seen (Req still high when hold_next is set).
  task automatic xact(input bit w, input logic [27:0] ad, input logic [127:0] d,
                      input bit hold_next, input bit scramble);
    int   acc;
    bit   seen;
    exp_t e;
    req = 1'b1; wr = w; a = ad; dout = d;
    acc = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    next_free = acc + LAT + 2;
    if (w) begin
      mdl[int'(ad[11:0])] = d;
      m_wrc = (m_wrc == SAT4) ? SAT4 : m_wrc + 1;
      e.di = last_rd;
    end else begin
      e.di = mdl.exists(int'(ad[11:0])) ? mdl[int'(ad[11:0])] : 'x;
      last_rd = e.di;
      m_rdc = (m_rdc == SAT4) ? SAT4 : m_rdc + 1;
    end
    e.is_wr = w; e.rdy_cyc = acc + LAT; e.rdc = m_rdc; e.wrc = m_wrc;
    sb.push_back(e);
    seen = 0;
    for (int n = 0; n < LAT + 8 && !seen; n++) begin
      @(negedge clk);
      chk("busy", 128'(busy4), 128'(cyc >= acc));
      if (scramble && cyc >= acc) begin
        a = 28'($urandom); dout = {$urandom, $urandom, $urandom, $urandom};
      end
      if (rdy4 === 1'b1) seen = 1;
    end
    if (!seen) chk("rdy_timeout", 128'(0), 128'(1));
    if (!hold_next) req = 1'b0;
  endtask

  logic [11:0] idx_tab [8] = '{12'h123, 12'h005, 12'h007, 12'h0FF,
                               12'hFFF, 12'h000, 12'h800, 12'h555};

  initial begin
    int           c0, acc;
    logic [127:0] v;
    logic [27:0]  ra;

    // Reset, then ten idle cycles with everything quiet.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rdy", 128'(rdy4), 128'(0));
      chk("idle_busy", 128'(busy4), 128'(0));
      chk("idle_di", di4, 128'(0));
      chk("idle_cnts", 128'({rdc4, wrc4}), 128'(0));
    end

    xact(1, 28'h0000123, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0, 0);
    @(negedge clk);
    xact(0, 28'h0000123, '0, 0, 0);
    @(negedge clk);
    xact(1, 28'h0001005, {4{32'h5A5A5A5A}}, 0, 0);
    xact(0, 28'h0003005, '0, 0, 0);

    // Held request with address/data churn during WAIT.
    for (int i = 0; i < 8; i++)
      xact(1, {16'($urandom), idx_tab[i]}, {$urandom, $urandom, $urandom, $urandom}, 1, 1);
    req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      ra = {16'($urandom), idx_tab[$urandom_range(0, 7)]};
      v  = {$urandom, $urandom, $urandom, $urandom};
      xact(1'($urandom), ra, v, 1'($urandom), 1'($urandom));
      if (req == 1'b0) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    req = 1'b0;
    repeat (3) @(negedge clk);

    // Abort a write to block 7 with a reset two edges after acceptance.
    req = 1'b1; wr = 1'b1; a = 28'h0000007; dout = '1;
    acc = cyc + 1;
    while (cyc < acc + 1) @(negedge clk);
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_rdc = 0; m_wrc = 0; last_rd = '0; next_free = 0;
    chk("abort_busy", 128'(busy4), 128'(0));
    chk("abort_di", di4, 128'(0));
    chk("abort_wr_count", 128'(wrc4), 128'(0));
    chk("abort_rd_count", 128'(rdc4), 128'(0));
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_rdy", 128'(rdy4), 128'(0));
    end
    xact(0, 28'h0000007, '0, 0, 0);
    repeat (2) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    // LATENCY=1: strobe one edge after acceptance, re-acceptance three edges later.
    v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    c0 = cyc;
    req1 = 1'b1; wr1 = 1'b1; a1 = 28'h0000003; do1 = v;
    @(negedge clk);
    chk("l1_wait_rdy", 128'(rdy1), 128'(0));
    chk("l1_wait_busy", 128'(busy1), 128'(1));
    @(negedge clk);
    chk("l1_done_rdy", 128'(rdy1), 128'(1));
    chk("l1_wr_count", 128'(wrc1), 128'(1));
    chk("l1_di_unchanged", di1, 128'(0));
    wr1 = 1'b0; a1 = 28'h5000003;
    @(negedge clk);
    chk("l1_turn_rdy", 128'(rdy1), 128'(0));
    chk("l1_turn_busy", 128'(busy1), 128'(0));
    @(negedge clk);
    chk("l1_reaccept_busy", 128'(busy1), 128'(1));
    chk("l1_reaccept_cyc", 128'(cyc - c0), 128'(4));
    @(negedge clk);
    chk("l1_rd_rdy", 128'(rdy1), 128'(1));
    chk("l1_rd_data", di1, v);
    chk("l1_rd_count", 128'(rdc1), 128'(1));
    req1 = 1'b0;
    @(negedge clk);
    chk("l1_end_rdy", 128'(rdy1), 128'(0));
    chk("l1_end_busy", 128'(busy1), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
